inst_fetch: RTL

- Fetch stage directly downstream of the PC register in the RV32 core.
- Takes the current PC, issues requests on the instruction bus (req/gnt, then rvalid response), and buffers returned instructions in a small queue.
- Presents one registered instruction/address pair to the IF/ID boundary.
- Back-pressures the PC via fetch_stall_o; discards stale fetches on jump using an epoch bit.

---
 rtl/inst_fetch_pkg.sv | 33 +++
 rtl/inst_fetch_if.sv | 28 ++
 rtl/inst_fetch_fifo.sv | 76 +++++++
 rtl/inst_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the RV32 instruction fetch stage: bus widths,
// hold levels, NOP encoding and the queue/tracker entry layouts.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int HOLD_FLAG_W = 3;

    localparam logic [INST_W-1:0]      NOP_INST_DEF = 32'h0000_0013;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_PC      = 3'd1;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_IF      = 3'd2;
    localparam logic                   JUMP_YES     = 1'b1;
    localparam logic                   RST_ACTIVE   = 1'b1;

    // Instruction waiting in the queue together with its fetch address.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] addr;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Outstanding request: address it was issued for and the epoch at issue.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] addr;
        logic                   epoch;
    } track_entry_t;

    // The IF/ID register may take a new instruction when the hold level
    // is below the IF freeze level.
    function automatic logic if_can_advance(input logic [HOLD_FLAG_W-1:0] hold);
        return (hold < HOLD_IF);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus: req/gnt address phase, in-order rvalid response phase.
interface inst_fetch_if import inst_fetch_pkg::*; ();

    logic                   req;
    logic [INST_ADDR_W-1:0] addr;
    logic                   gnt;
    logic                   rvalid;
    logic [INST_W-1:0]      rdata;

    // Fetch unit side.
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Memory side.
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with a single-cycle flush, used to queue
// returned instructions between the bus and the IF/ID register.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state register; only pointers and occupancy are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: RV32 fetch stage. Issues PC fetches on the instruction bus,
// tracks outstanding requests with an epoch bit so that responses belonging
// to a pre-jump stream are discarded, queues returned instructions and
// presents one registered instruction to decode.
// Optional build macro FETCH_BYPASS_EN: a response may load the IF/ID
// register directly when the queue is empty, saving one cycle of latency.
module inst_fetch import inst_fetch_pkg::*; #(
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   jump_flag_i,
    input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
    inst_fetch_if.master           ibus,
    output logic                   inst_valid_o,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    output logic                   fetch_stall_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Outstanding-request tracker (pointer-based circular array).
    track_entry_t  trk_q [DEPTH];
    logic [AW-1:0] trk_wr_q, trk_wr_d;
    logic [AW-1:0] trk_rd_q, trk_rd_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          epoch_q, epoch_d;

    // IF/ID output register.
    logic                   valid_q, valid_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic [INST_ADDR_W-1:0] addr_q, addr_d;

    // Queue interface.
    fetch_entry_t  q_wdata;
    fetch_entry_t  q_rdata;
    logic          q_push;
    logic          q_pop;
    logic          q_empty;
    logic [CW-1:0] q_count;

    logic          jump;
    logic          rst_act;
    logic [CW:0]   inflight;
    logic          req;
    logic          gnt_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          consume;
    logic          bypass;
    track_entry_t  trk_head;

    // Request issue, response classification and queue control.
    always_comb begin
        jump     = (jump_flag_i == JUMP_YES);
        rst_act  = (rst == RST_ACTIVE);
        inflight = {1'b0, outst_q} + {1'b0, q_count};
        req      = !rst_act && !jump && (inflight < (CW+1)'(DEPTH));
        gnt_fire = req && ibus.gnt;
        // A response with nothing outstanding cannot be matched; ignore it.
        rsp_fire = ibus.rvalid && (outst_q != '0);
        trk_head = trk_q[trk_rd_q];
        // Stale epoch or a response landing in the jump cycle is discarded.
        rsp_keep = rsp_fire && (trk_head.epoch == epoch_q) && !jump;
        consume  = !valid_q || if_can_advance(hold_flag_i);
`ifdef FETCH_BYPASS_EN
        bypass   = rsp_keep && q_empty && consume;
`else
        bypass   = 1'b0;
`endif
        q_push   = rsp_keep && !bypass;
        q_pop    = consume && !q_empty && !jump;
        q_wdata  = '{addr: trk_head.addr, inst: ibus.rdata};
    end

    // Tracker pointers, outstanding count and epoch next-state.
    always_comb begin
        trk_wr_d = trk_wr_q;
        trk_rd_d = trk_rd_q;
        epoch_d  = epoch_q;
        if (gnt_fire) begin
            trk_wr_d = trk_wr_q + AW'(1);
        end
        if (rsp_fire) begin
            trk_rd_d = trk_rd_q + AW'(1);
        end
        outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
        if (jump) begin
            epoch_d = ~epoch_q;
        end
    end

    // IF/ID register next-state: jump clears, else load on empty/consume.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        if (jump) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (consume) begin
            if (!q_empty) begin
                valid_d = 1'b1;
                inst_d  = q_rdata.inst;
                addr_d  = q_rdata.addr;
            end else if (bypass) begin
                valid_d = 1'b1;
                inst_d  = ibus.rdata;
                addr_d  = trk_head.addr;
            end else begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
        end
    end

    // Tracker control registers; reset drops every in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_wr_q <= '0;
            trk_rd_q <= '0;
            outst_q  <= '0;
            epoch_q  <= 1'b0;
        end else begin
            trk_wr_q <= trk_wr_d;
            trk_rd_q <= trk_rd_d;
            outst_q  <= outst_d;
            epoch_q  <= epoch_d;
        end
    end

    // Tracker payload: address and epoch captured on each granted request.
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            trk_q[trk_wr_q] <= '{addr: pc_i, epoch: epoch_q};
        end
    end

    // IF/ID output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump),
        .push_i  (q_push),
        .data_i  (q_wdata),
        .pop_i   (q_pop),
        .data_o  (q_rdata),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign ibus.req      = req;
    assign ibus.addr     = pc_i;
    assign fetch_stall_o = !gnt_fire;
    assign inst_valid_o  = valid_q;
    assign inst_o        = inst_q;
    assign inst_addr_o   = addr_q;

endmodule
